cmp_chunk_accumulator: RTL and testbench
========================================

// Module: cmp_chunk_accumulator
// PURPOSE
//  Downstream stage of the 3-bit magnitude comparator. Consumes its per-chunk
//  equal/greater/less flags and combines them into one wide comparison result.
//  Chunks arrive MSB-first, one per accepted transfer; NUM_CHUNKS chunks form
//  one comparison of (3*NUM_CHUNKS)-bit operands.
//  Valid/ready handshake on the input and on the output side.
// PARAMETERS
//  NUM_CHUNKS  4  chunks per comparison (>=2); operand width = 3*NUM_CHUNKS
//  CNT_W       $clog2(NUM_CHUNKS)  chunk counter width (derived, do not override)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      chunk flags valid
//  in_ready     out  1      stage can accept a chunk
//  in_equal     in   1      chunk A==B (from comparator)
//  in_greater   in   1      chunk A>B
//  in_less      in   1      chunk A<B
//  out_valid    out  1      wide result valid
//  out_ready    in   1      consumer accepts result
//  out_equal    out  1      wide A==B
//  out_greater  out  1      wide A>B
//  out_less     out  1      wide A<B
//  out_err      out  1      a chunk in this comparison had non-one-hot flags
//  busy         out  1      at least one chunk of a comparison accepted
// BEHAVIOUR
//  Clock/reset: one clock clk; rst synchronous, active-high.
//  Reset: state=ACCUM, count=0, decided=0, err=0; out_valid=0, out_* flags=0,
//   out_err=0, busy=0. in_ready=1 on the first cycle after reset release.
//  A transfer occurs on a cycle with valid&ready high at posedge clk.
//  FSM states:
//   ACCUM: in_ready=1, out_valid=0. On each accepted chunk:
//    - flags not exactly one-hot -> err<=1 (sticky until result consumed)
//    - if !decided and in_greater -> decided<=1, res<=GT
//    - if !decided and in_less    -> decided<=1, res<=LT
//    - if in_equal -> no change (res stays EQ while undecided)
//    - later chunks never override a decided result
//    - count==NUM_CHUNKS-1 -> count<=0, go HOLD; else count<=count+1
//   HOLD: in_ready=0, out_valid=1; outputs registered and stable.
//    On out_ready=1 -> ACCUM; clear decided/err/res to EQ.
//  Output encoding in HOLD: err=1 -> out_err=1, all three flags 0;
//   else exactly one of out_equal/out_greater/out_less=1 per res.
//   Outside HOLD all out_* flags and out_err are 0.
//  Latency: out_valid rises the cycle after the last chunk is accepted.
//  Throughput: NUM_CHUNKS+1 cycles per comparison with no backpressure.
//  busy=1 while count!=0 in ACCUM, and in HOLD.
//  in_valid low cycles in ACCUM are bubbles: no state change.
//  In HOLD with in_valid=1 and out_ready=1 in the same cycle: the chunk is NOT
//   accepted (in_ready=0); it may be accepted the next cycle.
//  out_ready held low in HOLD: result held indefinitely, no input consumed.
//  rst mid-comparison or in HOLD: partial/pending result discarded, reset values.
//  No combinational path from in_* to out_*; in_ready depends only on state.
// TESTING (NUM_CHUNKS=4)
//  1. Chunks EQ,EQ,EQ,EQ back-to-back, out_ready=1 -> out_valid one cycle after
//     4th chunk, out_equal=1, out_err=0; in_ready back to 1 the next cycle.
//  2. Chunks EQ,GT,LT,LT -> out_greater=1 (first deciding chunk wins).
//     Chunks LT,GT,GT,GT -> out_less=1.
//  3. Chunk 2 with in_greater=1 and in_less=1, others EQ -> out_err=1, all flags
//     0; the next comparison EQ x4 reports out_equal=1 and out_err=0.
//  4. out_ready=0 for 5 cycles in HOLD while in_valid=1 -> out_* stable,
//     in_ready=0, no chunk consumed; on out_ready=1 the next chunk is counted
//     as chunk 0.
//  5. rst pulsed after 2 chunks (GT,EQ) -> busy=0, count=0; next EQ x4 gives
//     out_equal=1.
//  6. Random in_valid bubbles over 200 comparisons vs. a 12-bit A/B reference
//     model -> every result matches; one result per 4 accepted chunks.

Source files
------------

// File: rtl/cmp_chunk_accumulator_if.sv
// Handshake bundle between the 3-bit chunk comparator, this accumulator and
// the consumer of the wide comparison result.
interface cmp_chunk_accumulator_if;
    logic in_valid;
    logic in_ready;
    logic in_equal;
    logic in_greater;
    logic in_less;
    logic out_valid;
    logic out_ready;
    logic out_equal;
    logic out_greater;
    logic out_less;
    logic out_err;
    logic busy;

    modport master (
        output in_valid, in_equal, in_greater, in_less, out_ready,
        input  in_ready, out_valid, out_equal, out_greater, out_less, out_err, busy
    );

    modport slave (
        input  in_valid, in_equal, in_greater, in_less, out_ready,
        output in_ready, out_valid, out_equal, out_greater, out_less, out_err, busy
    );
endinterface

// File: rtl/cmp_chunk_accumulator.sv
// Folds NUM_CHUNKS MSB-first per-chunk equal/greater/less flags into one wide
// comparison result, with valid/ready on both sides.
module cmp_chunk_accumulator #(
    parameter int NUM_CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cmp_chunk_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_CHUNKS);

    typedef enum logic {ST_ACCUM, ST_HOLD} state_t;
    typedef enum logic [1:0] {RES_EQ, RES_GT, RES_LT} res_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_decided;
    logic             r_err;
    res_t             r_res;
    logic             r_out_valid;
    logic             r_out_equal;
    logic             r_out_greater;
    logic             r_out_less;
    logic             r_out_err;

    logic             w_accept;
    logic             w_last;
    logic             w_err_nxt;
    logic             w_decided_nxt;
    res_t             w_res_nxt;

    // Result state as it will be after the chunk currently presented is absorbed.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_accept      = bus.in_valid && (r_state == ST_ACCUM);
        w_last        = (r_count == CNT_W'(NUM_CHUNKS - 1));
        w_err_nxt     = r_err || !$onehot({bus.in_equal, bus.in_greater, bus.in_less});
        w_decided_nxt = r_decided;
        w_res_nxt     = r_res;
        if (!r_decided) begin
            if (bus.in_greater) begin
                w_decided_nxt = 1'b1;
                w_res_nxt     = RES_GT;
            end else if (bus.in_less) begin
                w_decided_nxt = 1'b1;
                w_res_nxt     = RES_LT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_ACCUM;
            r_count       <= '0;
            r_decided     <= 1'b0;
            r_err         <= 1'b0;
            r_res         <= RES_EQ;
            r_out_valid   <= 1'b0;
            r_out_equal   <= 1'b0;
            r_out_greater <= 1'b0;
            r_out_less    <= 1'b0;
            r_out_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_err     <= w_err_nxt;
                        r_decided <= w_decided_nxt;
                        r_res     <= w_res_nxt;
                        if (w_last) begin
                            r_count       <= '0;
                            r_state       <= ST_HOLD;
                            r_out_valid   <= 1'b1;
                            r_out_err     <= w_err_nxt;
                            r_out_equal   <= !w_err_nxt && (w_res_nxt == RES_EQ);
                            r_out_greater <= !w_err_nxt && (w_res_nxt == RES_GT);
                            r_out_less    <= !w_err_nxt && (w_res_nxt == RES_LT);
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Input stays blocked this cycle even if the result is taken.
                    if (bus.out_ready) begin
                        r_state       <= ST_ACCUM;
                        r_decided     <= 1'b0;
                        r_err         <= 1'b0;
                        r_res         <= RES_EQ;
                        r_out_valid   <= 1'b0;
                        r_out_equal   <= 1'b0;
                        r_out_greater <= 1'b0;
                        r_out_less    <= 1'b0;
                        r_out_err     <= 1'b0;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == ST_ACCUM);
    assign bus.out_valid   = r_out_valid;
    assign bus.out_equal   = r_out_equal;
    assign bus.out_greater = r_out_greater;
    assign bus.out_less    = r_out_less;
    assign bus.out_err     = r_out_err;
    assign bus.busy        = (r_state == ST_HOLD) || (r_count != '0);
endmodule

// File: tb/tb_cmp_chunk_accumulator.sv
// Directed table plus hand-written corner sequences and a randomized 12-bit
// operand comparison against a whole-word reference.
module tb_cmp_chunk_accumulator;
    // Chunk flag encodings {equal, greater, less}
    localparam logic [2:0] C_EQ  = 3'b100;
    localparam logic [2:0] C_GT  = 3'b010;
    localparam logic [2:0] C_LT  = 3'b001;
    localparam logic [2:0] C_BAD = 3'b011;
    localparam logic [2:0] C_NON = 3'b000;
    localparam logic [2:0] C_EQG = 3'b110;
    // Expected result encodings {err, equal, greater, less}
    localparam logic [3:0] E_EQ  = 4'b0100;
    localparam logic [3:0] E_GT  = 4'b0010;
    localparam logic [3:0] E_LT  = 4'b0001;
    localparam logic [3:0] E_ERR = 4'b1000;

    typedef struct packed {
        logic [3:0][2:0] c;   // c[3] is sent first
        logic [3:0]      e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[10];

    cmp_chunk_accumulator_if bus();

    cmp_chunk_accumulator #(.NUM_CHUNKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] res_bits();
        return 32'({bus.out_err, bus.out_equal, bus.out_greater, bus.out_less});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_chunk(input logic [2:0] c);
        bus.in_valid = 1'b1;
        {bus.in_equal, bus.in_greater, bus.in_less} = c;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Called one cycle after the last chunk; holds the result off for 'hold' cycles.
    task automatic expect_result(input logic [3:0] e, input int hold, input string nm);
        check({nm, " out_valid"}, 32'(bus.out_valid), 1);
        check({nm, " result"}, res_bits(), 32'(e));
        check({nm, " in_ready in hold"}, 32'(bus.in_ready), 0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick();
            check({nm, " held valid"}, 32'(bus.out_valid), 1);
            check({nm, " held result"}, res_bits(), 32'(e));
            check({nm, " held in_ready"}, 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check({nm, " valid dropped"}, 32'(bus.out_valid), 0);
        check({nm, " in_ready back"}, 32'(bus.in_ready), 1);
        check({nm, " idle busy"}, 32'(bus.busy), 0);
    endtask

    task automatic send_cmp(input logic [3:0][2:0] c, input logic [3:0] e,
                            input int hold, input string nm);
        for (int i = 3; i >= 0; i--) begin
            drive_chunk(c[i]);
            if (i > 0) begin
                check({nm, " early valid"}, 32'(bus.out_valid), 0);
                check({nm, " busy"}, 32'(bus.busy), 1);
            end
        end
        expect_result(e, hold, nm);
    endtask

    initial begin
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  e;
        logic [2:0]  ca;
        logic [2:0]  cb;

        tbl[0] = '{c: {C_EQ,  C_EQ,  C_EQ,  C_EQ},  e: E_EQ};
        tbl[1] = '{c: {C_EQ,  C_GT,  C_LT,  C_LT},  e: E_GT};
        tbl[2] = '{c: {C_LT,  C_GT,  C_GT,  C_GT},  e: E_LT};
        tbl[3] = '{c: {C_EQ,  C_EQ,  C_BAD, C_EQ},  e: E_ERR};
        tbl[4] = '{c: {C_EQ,  C_EQ,  C_EQ,  C_EQ},  e: E_EQ};
        tbl[5] = '{c: {C_EQ,  C_EQ,  C_EQ,  C_GT},  e: E_GT};
        tbl[6] = '{c: {C_EQ,  C_EQ,  C_EQ,  C_LT},  e: E_LT};
        tbl[7] = '{c: {C_GT,  C_EQ,  C_EQ,  C_NON}, e: E_ERR};
        tbl[8] = '{c: {C_EQG, C_EQ,  C_EQ,  C_EQ},  e: E_ERR};
        tbl[9] = '{c: {C_LT,  C_EQ,  C_EQ,  C_EQ},  e: E_LT};

        bus.in_valid   = 1'b0;
        bus.in_equal   = 1'b0;
        bus.in_greater = 1'b0;
        bus.in_less    = 1'b0;
        bus.out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset result", res_bits(), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset in_ready", 32'(bus.in_ready), 1);

        for (int v = 0; v < 10; v++)
            send_cmp(tbl[v].c, tbl[v].e, 0, $sformatf("vec%0d", v));

        // Backpressure with a chunk waiting: nothing consumed while in HOLD or
        // on the cycle the result is taken; that chunk then counts as chunk 0.
        send_cmp({C_EQ, C_GT, C_EQ, C_EQ}, E_GT, 0, "pre_bp");
        for (int i = 0; i < 4; i++) drive_chunk(C_EQ);
        bus.in_valid = 1'b1;
        {bus.in_equal, bus.in_greater, bus.in_less} = C_LT;
        expect_result(E_EQ, 5, "bp");
        send_cmp({C_LT, C_EQ, C_EQ, C_EQ}, E_LT, 0, "after_bp");

        // Reset mid-comparison discards the partial result.
        drive_chunk(C_GT);
        drive_chunk(C_EQ);
        check("mid busy", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst busy", 32'(bus.busy), 0);
        check("mid rst in_ready", 32'(bus.in_ready), 1);
        send_cmp({C_EQ, C_EQ, C_EQ, C_EQ}, E_EQ, 0, "post_mid_rst");

        // Reset while holding a result discards it.
        for (int i = 0; i < 4; i++) drive_chunk(C_GT);
        bus.out_ready = 1'b0;
        check("hold pre rst valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("hold rst valid", 32'(bus.out_valid), 0);
        check("hold rst result", res_bits(), 0);
        check("hold rst in_ready", 32'(bus.in_ready), 1);
        send_cmp({C_EQ, C_EQ, C_LT, C_EQ}, E_LT, 0, "post_hold_rst");

        // Random operands with input bubbles and output backpressure.
        for (int n = 0; n < 200; n++) begin
            a = 12'($urandom_range(0, 4095));
            b = (n % 4 == 0) ? a : 12'($urandom_range(0, 4095));
            if (n % 8 == 1) b = a ^ 12'h001;
            e = (a == b) ? E_EQ : ((a > b) ? E_GT : E_LT);
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    {bus.in_equal, bus.in_greater, bus.in_less} = 3'($urandom_range(0, 7));
                    tick();
                end
                ca = a[11 - 3*i -: 3];
                cb = b[11 - 3*i -: 3];
                drive_chunk({ca == cb, ca > cb, ca < cb});
                if (i < 3) check($sformatf("rnd%0d early valid", n), 32'(bus.out_valid), 0);
            end
            expect_result(e, $urandom_range(0, 2), $sformatf("rnd%0d a=%0h b=%0h", n, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
